// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/redirect sequencer: branch operand forward selects, load-use stalls
// with a registered stall FSM, taken branch/jump redirect, and saturating perf counters.
module id_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic [1:0]       ID_Jump,
  input  logic             ID_BranchCond,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegDest,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_RegDest,
  input  logic             WB_RegWrite,
  input  logic [4:0]       WB_RegDest,
  output logic [1:0]       BranchSrcA,
  output logic [1:0]       BranchSrcB,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Redirect,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0] state;
  logic       cnt;

  function automatic logic match(input logic we, input logic [4:0] dest, input logic [4:0] r);
    return we && (dest == r) && (r != 5'd0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_ld,
                                         input logic mem_m, input logic mem_ld,
                                         input logic wb_m);
    if (ex_m && !ex_ld)        return 2'b01;
    else if (mem_m && !mem_ld) return 2'b10;
    else if (wb_m)             return 2'b11;
    else                       return 2'b00;
  endfunction

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic ctrl_use, ld_ex, ld_mem, hz1, hz2, stall, redirect_req;
  logic [1:0] sel_a, sel_b;

  always_comb begin
    ex_a  = match(EX_RegWrite, EX_RegDest, ID_rs);
    ex_b  = match(EX_RegWrite, EX_RegDest, ID_rt);
    mem_a = match(MEM_RegWrite, MEM_RegDest, ID_rs);
    mem_b = match(MEM_RegWrite, MEM_RegDest, ID_rt);
    wb_a  = match(WB_RegWrite, WB_RegDest, ID_rs);
    wb_b  = match(WB_RegWrite, WB_RegDest, ID_rt);
    sel_a = fwd_sel(ex_a, EX_MemRead, mem_a, MEM_MemRead, wb_a);
    sel_b = fwd_sel(ex_b, EX_MemRead, mem_b, MEM_MemRead, wb_b);

    ctrl_use = ID_Branch || (ID_Jump == 2'b10);
    ld_ex    = EX_MemRead  && ((ID_UsesRs && ex_a)  || (ID_UsesRt && ex_b));
    ld_mem   = MEM_MemRead && ((ID_UsesRs && mem_a) || (ID_UsesRt && mem_b));
    hz2      = ctrl_use && ld_ex;
    hz1      = ctrl_use ? ld_mem : ld_ex;
    stall    = (state == STALL) || hz2 || hz1;
    redirect_req = (ID_Jump != 2'b00) || (ID_Branch && ID_BranchCond);
  end

  always_comb begin
    BranchSrcA = 2'b00;
    BranchSrcB = 2'b00;
    PCWrite    = 1'b0;
    IFIDWrite  = 1'b0;
    IFIDFlush  = 1'b1;
    IDEXFlush  = 1'b1;
    Redirect   = 1'b0;
    if (reset) begin
      BranchSrcA = sel_a;
      BranchSrcB = sel_b;
      // a stall suppresses any redirect so the branch re-evaluates once operands arrive
      if (stall) begin
        IFIDFlush = 1'b0;
      end else begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IDEXFlush = 1'b0;
        IFIDFlush = redirect_req;
        Redirect  = redirect_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      cnt        <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hz2) begin
            state <= STALL;
            cnt   <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 1'b0;
        end
      endcase
      if (stall && (StallCount != '1))
        StallCount <= StallCount + 1'b1;
      if (Redirect && (FlushCount != '1))
        FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl; a second CNT_W=4 instance checks saturation.
module tb_id_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ID_rs, ID_rt;
  logic       ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchCond;
  logic [1:0] ID_Jump;
  logic       EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead, WB_RegWrite;
  logic [4:0] EX_RegDest, MEM_RegDest, WB_RegDest;

  logic [1:0]  BranchSrcA, BranchSrcB, s_BranchSrcA, s_BranchSrcB;
  logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Redirect;
  logic        s_PCWrite, s_IFIDWrite, s_IFIDFlush, s_IDEXFlush, s_Redirect;
  logic [15:0] StallCount, FlushCount;
  logic [3:0]  s_StallCount, s_FlushCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
    .ID_Jump(ID_Jump), .ID_BranchCond(ID_BranchCond),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_RegDest(MEM_RegDest),
    .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
    .BranchSrcA(BranchSrcA), .BranchSrcB(BranchSrcB), .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .Redirect(Redirect), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  id_hazard_ctrl #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
    .ID_Jump(ID_Jump), .ID_BranchCond(ID_BranchCond),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_RegDest(MEM_RegDest),
    .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
    .BranchSrcA(s_BranchSrcA), .BranchSrcB(s_BranchSrcB), .PCWrite(s_PCWrite),
    .IFIDWrite(s_IFIDWrite), .IFIDFlush(s_IFIDFlush), .IDEXFlush(s_IDEXFlush),
    .Redirect(s_Redirect), .StallCount(s_StallCount), .FlushCount(s_FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_Jump = 2'b00; ID_BranchCond = 1'b0;
    EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_RegDest = 5'd0;
    MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_RegDest = 5'd0;
    WB_RegWrite = 1'b0; WB_RegDest = 5'd0;
  endtask

  task automatic beq(input logic [4:0] rs, input logic [4:0] rt, input logic cond);
    ID_rs = rs; ID_rt = rt; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
    ID_Branch = 1'b1; ID_BranchCond = cond;
  endtask

  task automatic chk_stall(input string tag);
    chk({tag, ".PCWrite"},   PCWrite,   1'b0);
    chk({tag, ".IFIDWrite"}, IFIDWrite, 1'b0);
    chk({tag, ".IDEXFlush"}, IDEXFlush, 1'b1);
    chk({tag, ".IFIDFlush"}, IFIDFlush, 1'b0);
    chk({tag, ".Redirect"},  Redirect,  1'b0);
  endtask

  task automatic chk_run(input string tag, input logic redir);
    chk({tag, ".PCWrite"},   PCWrite,   1'b1);
    chk({tag, ".IFIDWrite"}, IFIDWrite, 1'b1);
    chk({tag, ".IDEXFlush"}, IDEXFlush, 1'b0);
    chk({tag, ".IFIDFlush"}, IFIDFlush, redir);
    chk({tag, ".Redirect"},  Redirect,  redir);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".PCWrite"},   PCWrite,   1'b0);
    chk({tag, ".IFIDWrite"}, IFIDWrite, 1'b0);
    chk({tag, ".IFIDFlush"}, IFIDFlush, 1'b1);
    chk({tag, ".IDEXFlush"}, IDEXFlush, 1'b1);
    chk({tag, ".Redirect"},  Redirect,  1'b0);
    chk({tag, ".SrcA"},      BranchSrcA, 2'b00);
    chk({tag, ".SrcB"},      BranchSrcB, 2'b00);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outs("rst");
    chk("rst.StallCount", StallCount, 16'd0);
    chk("rst.FlushCount", FlushCount, 16'd0);

    // Load-use into a branch: two stall cycles, then WB forwarding and taken redirect
    @(negedge clk); reset = 1'b1; idle();
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_RegDest = 5'd8; beq(5'd8, 5'd9, 1'b1);
    #1; chk_stall("t1.c0");
    @(negedge clk); idle(); beq(5'd8, 5'd9, 1'b1);
    MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_RegDest = 5'd8;
    #1; chk_stall("t1.c1");
    @(negedge clk); idle(); beq(5'd8, 5'd9, 1'b1);
    WB_RegWrite = 1'b1; WB_RegDest = 5'd8;
    #1; chk_run("t1.c2", 1'b1);
    chk("t1.SrcA", BranchSrcA, 2'b11);
    chk("t1.SrcB", BranchSrcB, 2'b00);
    chk("t1.StallCount", StallCount, 16'd2);
    @(negedge clk); idle(); #1;
    chk("t1.FlushCount", FlushCount, 16'd1);
    chk_run("t1.idle", 1'b0);

    // ALU producer in EX: forwarded without stall; redirect follows the condition
    @(negedge clk); idle();
    EX_RegWrite = 1'b1; EX_RegDest = 5'd8; beq(5'd8, 5'd0, 1'b0);
    #1; chk_run("t2.nt", 1'b0);
    chk("t2.SrcA", BranchSrcA, 2'b01);
    chk("t2.SrcB", BranchSrcB, 2'b00);
    ID_BranchCond = 1'b1;
    #1; chk_run("t2.tk", 1'b1);

    // EX beats MEM; a write to $0 never forwards
    @(negedge clk); idle();
    EX_RegWrite = 1'b1; EX_RegDest = 5'd8; MEM_RegWrite = 1'b1; MEM_RegDest = 5'd8;
    WB_RegWrite = 1'b1; WB_RegDest = 5'd8; beq(5'd8, 5'd8, 1'b0);
    #1; chk("t3.prioA", BranchSrcA, 2'b01);
    chk("t3.prioB", BranchSrcB, 2'b01);
    EX_RegWrite = 1'b0;
    #1; chk("t3.memA", BranchSrcA, 2'b10);
    @(negedge clk); idle();
    EX_RegWrite = 1'b1; EX_RegDest = 5'd0; beq(5'd0, 5'd0, 1'b0);
    #1; chk("t3.zeroA", BranchSrcA, 2'b00);
    chk_run("t3.zero", 1'b0);

    // Load-use into ALU instruction: exactly one stall
    @(negedge clk); idle();
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_RegDest = 5'd5;
    ID_rs = 5'd5; ID_rt = 5'd5; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
    #1; chk_stall("t4.c0");
    chk("t4.StallCount", StallCount, 16'd2);
    @(negedge clk); idle();
    MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_RegDest = 5'd5;
    ID_rs = 5'd5; ID_rt = 5'd5; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1;
    #1; chk_run("t4.c1", 1'b0);
    chk("t4.StallCount", StallCount, 16'd3);

    // Jumps: j redirects at once; jr waits one cycle on a MEM load
    @(negedge clk); idle(); ID_Jump = 2'b01;
    #1; chk_run("t5.j", 1'b1);
    @(negedge clk); idle(); ID_Jump = 2'b10; ID_rs = 5'd31; ID_UsesRs = 1'b1;
    MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_RegDest = 5'd31;
    #1; chk_stall("t5.jr0");
    @(negedge clk); idle(); ID_Jump = 2'b10; ID_rs = 5'd31; ID_UsesRs = 1'b1;
    WB_RegWrite = 1'b1; WB_RegDest = 5'd31;
    #1; chk_run("t5.jr1", 1'b1);
    chk("t5.SrcA", BranchSrcA, 2'b11);
    chk("t5.StallCount", StallCount, 16'd4);
    chk("t5.FlushCount", FlushCount, 16'd3);

    // rs needs 1 stall (MEM load), rt needs 2 (EX load): two stalls
    @(negedge clk); idle(); beq(5'd3, 5'd4, 1'b0);
    MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_RegDest = 5'd3;
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_RegDest = 5'd4;
    #1; chk("t6.FlushCount", FlushCount, 16'd4);
    chk_stall("t6.c0");
    @(negedge clk); idle(); beq(5'd3, 5'd4, 1'b0);
    #1; chk_stall("t6.c1");
    @(negedge clk); idle(); #1;
    chk_run("t6.c2", 1'b0);
    chk("t6.StallCount", StallCount, 16'd6);

    // Reset while in STALL aborts the stall
    @(negedge clk); idle(); beq(5'd8, 5'd9, 1'b0);
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_RegDest = 5'd8;
    #1; chk_stall("t7.c0");
    @(negedge clk); reset = 1'b0; idle(); beq(5'd8, 5'd9, 1'b0);
    WB_RegWrite = 1'b1; WB_RegDest = 5'd8;
    #1; chk_reset_outs("t7.rst");
    @(negedge clk); reset = 1'b1; idle(); #1;
    chk_run("t7.post", 1'b0);
    chk("t7.StallCount", StallCount, 16'd0);
    chk("t7.FlushCount", FlushCount, 16'd0);

    // 20 consecutive stalls: the 4-bit counter saturates
    @(negedge clk); idle();
    EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_RegDest = 5'd5; ID_rs = 5'd5; ID_UsesRs = 1'b1;
    repeat (20) @(negedge clk);
    idle(); #1;
    chk("t8.small", s_StallCount, 4'd15);
    chk("t8.wide", StallCount, 16'd20);
    chk("t8.small_pc", s_PCWrite, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule
